// File: rtl/spi_adc_sampler.sv
// SPI-master sampler for serial ADCs: round-robin channel scan, field extract, threshold flags.
// Latency: data/data_valid land in the cycle cs_n rises, 2*CLK_DIV*(FRAME_BITS+1) clk after cs_n falls.
// Backpressure: none; start_en is a level gating continuous conversions, sampled in IDLE and at end of GAP.
// Optional build macro SPI_ADC_AVG_EN: per-channel exponential averaging of the reported value.
module spi_adc_sampler #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 3,
    parameter int DATA_W     = 12,
    parameter int NUM_CH     = 1,
    parameter int GAP_CYCLES = 16,
    parameter logic [DATA_W-1:0] THRESH_HI = 12'hC00,
    parameter logic [DATA_W-1:0] THRESH_LO = 12'h100,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_en,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic              cs_n,
    output logic [DATA_W-1:0] data,
    output logic [CH_W-1:0]   data_ch,
    output logic              data_valid,
    output logic              busy,
    output logic              above_hi,
    output logic              below_lo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    // One shared cycle counter serves both the SCK half-periods and the inter-frame gap.
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] CAP_FIRST = BIT_W'(LEAD_BITS);
    localparam logic [BIT_W-1:0] CAP_END   = BIT_W'(LEAD_BITS + DATA_W);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic                    phase_q, phase_d;   // 0: sck-low half, 1: sck-high half
    logic [CH_W-1:0]         ptr_q, ptr_d;
    logic [FRAME_BITS-1:0]   tx_sr_q, tx_sr_d;   // MSB drives mosi
    logic [DATA_W-1:0]       rx_sr_q, rx_sr_d;
    logic                    cs_n_q, cs_n_d;
    logic                    sck_q, sck_d;
    logic                    busy_q, busy_d;
    logic [DATA_W-1:0]       data_q;
    logic [CH_W-1:0]         data_ch_q;
    logic                    data_valid_q;
    logic                    above_hi_q, below_lo_q;

    logic                    sample_pt;
    logic                    frame_done;
    logic [FRAME_BITS-1:0]   tx_init;
    logic [DATA_W-1:0]       result;

    // Outgoing frame word: channel index in the first CH_W bits, MSB-first, rest zero.
    always_comb begin
        tx_init = '0;
        if (NUM_CH > 1) begin
            tx_init[FRAME_BITS-1 -: CH_W] = ptr_q;
        end
    end

    // Next-state logic for the frame sequencer, shift registers and registered pin levels.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        phase_d    = phase_q;
        ptr_d      = ptr_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        sample_pt  = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_en) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    tx_sr_d = tx_init;
                end
            end
            S_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                // First cycle of the sck-high half is the rising-edge cycle.
                sample_pt = phase_q && (cnt_q == '0);
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_HOLD;
                            tx_sr_d = '0;
                        end else begin
                            // mosi advances together with the falling sck edge.
                            bit_d   = bit_q + 1'b1;
                            tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d    = S_GAP;
                    cnt_d      = '0;
                    frame_done = 1'b1;
                    ptr_d      = (ptr_q == CH_LAST) ? '0 : ptr_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    if (start_en) begin
                        state_d = S_SETUP;
                        tx_sr_d = tx_init;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sample_pt && (bit_q >= CAP_FIRST) && (bit_q < CAP_END)) begin
            rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
        end

        cs_n_d = !((state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD));
        sck_d  = (state_d == S_SHIFT) && phase_d;
        busy_d = (state_d != S_IDLE);
    end

`ifdef SPI_ADC_AVG_EN
    logic [DATA_W-1:0]     avg_q [NUM_CH];
    logic [NUM_CH-1:0]     seen_q;
    logic signed [DATA_W:0] avg_diff;
    logic signed [DATA_W:0] avg_step;
    logic signed [DATA_W:0] avg_sum;

    // avg += (sample - avg) >>> 2, floor rounding; first sample of a channel loads directly.
    always_comb begin
        avg_diff = $signed({1'b0, rx_sr_q}) - $signed({1'b0, avg_q[ptr_q]});
        avg_step = avg_diff >>> 2;
        avg_sum  = $signed({1'b0, avg_q[ptr_q]}) + avg_step;
        result   = seen_q[ptr_q] ? avg_sum[DATA_W-1:0] : rx_sr_q;
    end

    // Per-channel average state, written back on each completed frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                avg_q[i] <= '0;
            end
        end else if (frame_done) begin
            avg_q[ptr_q]  <= result;
            seen_q[ptr_q] <= 1'b1;
        end
    end
`else
    // Without averaging the raw captured field is reported.
    always_comb begin
        result = rx_sr_q;
    end
`endif

    // State, counters and registered outputs; reset also aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            phase_q      <= 1'b0;
            ptr_q        <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            cs_n_q       <= 1'b1;
            sck_q        <= 1'b0;
            busy_q       <= 1'b0;
            data_q       <= '0;
            data_ch_q    <= '0;
            data_valid_q <= 1'b0;
            above_hi_q   <= 1'b0;
            below_lo_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            phase_q      <= phase_d;
            ptr_q        <= ptr_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            cs_n_q       <= cs_n_d;
            sck_q        <= sck_d;
            busy_q       <= busy_d;
            data_valid_q <= frame_done;
            if (frame_done) begin
                data_q     <= result;
                data_ch_q  <= ptr_q;
                above_hi_q <= (result > THRESH_HI);
                below_lo_q <= (result < THRESH_LO);
            end
        end
    end

    assign mosi       = tx_sr_q[FRAME_BITS-1];
    assign sck        = sck_q;
    assign cs_n       = cs_n_q;
    assign data       = data_q;
    assign data_ch    = data_ch_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign above_hi   = above_hi_q;
    assign below_lo   = below_lo_q;

endmodule

// File: tb/tb_spi_adc_sampler.sv
// Directed bench for spi_adc_sampler: default single-channel instance plus a 4-channel instance.
// Expected values are hand-computed from the frame timing and test words.
// The ADC model shifts a 16-bit word out MSB-first, advancing on each falling sck.
module tb_spi_adc_sampler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_en;
    logic        miso;
    logic        mosi, sck, cs_n, data_valid, busy, above_hi, below_lo;
    logic [11:0] data;
    logic [0:0]  data_ch;

    logic        start_en4;
    logic        miso4;
    logic        mosi4, sck4, cs_n4, dv4, busy4, ah4, bl4;
    logic [11:0] data4;
    logic [1:0]  data_ch4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_adc_sampler u_dut (
        .clk(clk), .reset(reset), .start_en(start_en), .miso(miso),
        .mosi(mosi), .sck(sck), .cs_n(cs_n), .data(data), .data_ch(data_ch),
        .data_valid(data_valid), .busy(busy), .above_hi(above_hi), .below_lo(below_lo)
    );

    spi_adc_sampler #(.NUM_CH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start_en(start_en4), .miso(miso4),
        .mosi(mosi4), .sck(sck4), .cs_n(cs_n4), .data(data4), .data_ch(data_ch4),
        .data_valid(dv4), .busy(busy4), .above_hi(ah4), .below_lo(bl4)
    );

    assign miso4 = 1'b1;

    // ADC model for the default instance.
    logic [15:0] tx_word = 16'h0;
    int          adc_idx = 0;
    logic        adc_prev_sck = 1'b0;
    always @(negedge clk) begin
        if (cs_n) adc_idx = 0;
        else if (adc_prev_sck && !sck) adc_idx = adc_idx + 1;
        adc_prev_sck = sck;
        miso = (adc_idx < 16) ? tx_word[4'(15 - adc_idx)] : 1'b0;
    end

    function automatic logic [15:0] mk(input logic [11:0] v);
        return {3'b000, v, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int   f_lat, f_len, f_pulses, f_hi, f_dv, f_mosi;
    logic prev_hi, prev_lo;

    task automatic measure_frame();
        logic ps;
        f_lat = 0;
        while (cs_n && f_lat < 60) begin @(negedge clk); f_lat++; end
        f_len = 0; f_pulses = 0; f_hi = 0; f_dv = 0; f_mosi = 0;
        ps = sck;
        while (!cs_n && f_len < 400) begin
            if (data_valid) f_dv++;
            if (mosi) f_mosi++;
            @(negedge clk);
            f_len++;
            if (sck && !ps) f_pulses++;
            if (sck) f_hi++;
            ps = sck;
        end
    endtask

    task automatic wait_valid();
        int c = 0;
        prev_hi = above_hi; prev_lo = below_lo;
        while (!data_valid && c < 500) begin
            prev_hi = above_hi; prev_lo = below_lo;
            @(negedge clk); c++;
        end
    endtask

    logic [11:0] t4_val  [6] = '{12'hD00, 12'h080, 12'h800, 12'hC00, 12'h100, 12'hC01};
    logic [1:0]  t4_flag [6] = '{2'b10,   2'b01,   2'b00,   2'b00,   2'b00,   2'b10};

    int          c, r, nv, vpos, lows, g;
    logic        ps;
    logic [1:0]  prev_flag;
    logic [1:0]  kk;
    logic [15:0] mword;

    initial begin
        reset = 1'b1; start_en = 1'b0; start_en4 = 1'b0;
        tx_word = mk(12'hA5C);
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_pins", {cs_n, sck, mosi, data_valid, busy, above_hi, below_lo}, 7'b1000000);
        chk("reset_data", {data, data_ch}, 13'h0);
        chk("reset_pins4", {cs_n4, sck4, mosi4, dv4, busy4, ah4, bl4, data4, data_ch4}, 21'h100000);

        // Test 1: single frame timing and capture
        reset = 1'b0; start_en = 1'b1;
        measure_frame();
        chk("t1_cs_fall_lat", f_lat, 1);
        chk("t1_frame_len", f_len, 136);
        chk("t1_sck_pulses", f_pulses, 16);
        chk("t1_sck_high_cycles", f_hi, 64);
        chk("t1_no_early_valid", f_dv, 0);
        chk("t1_mosi_zero", f_mosi, 0);
        chk("t1_valid_at_cs_rise", {cs_n, data_valid, busy}, 3'b111);
        chk("t1_data", data, 12'hA5C);
        chk("t1_data_ch", data_ch, 1'b0);
        chk("t1_flags", {above_hi, below_lo}, 2'b00);
        @(negedge clk);
        chk("t1_valid_one_cycle", data_valid, 1'b0);

        // Test 4: threshold flags, including the equal-to-threshold boundaries
        prev_flag = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tx_word = mk(t4_val[i]);
            @(negedge clk);
            wait_valid();
            chk("t4_valid", data_valid, 1'b1);
            chk("t4_data", data, t4_val[i]);
            chk("t4_flags_pre", {prev_hi, prev_lo}, prev_flag);
            chk("t4_flags", {above_hi, below_lo}, t4_flag[i]);
            prev_flag = t4_flag[i];
        end

        // Test 5: drop start_en at frame bit 4
        tx_word = mk(12'h123);
        c = 0;
        while (cs_n && c < 60) begin @(negedge clk); c++; end
        chk("t5_cs_fall", cs_n, 1'b0);
        r = 0; ps = sck;
        while (r < 5 && c < 200) begin
            @(negedge clk); c++;
            if (sck && !ps) r++;
            ps = sck;
        end
        chk("t5_at_bit4", r, 5);
        start_en = 1'b0;
        nv = 0; vpos = -100; c = 0;
        while (busy && c < 600) begin
            if (data_valid) begin nv++; vpos = c; end
            @(negedge clk); c++;
        end
        chk("t5_one_valid", nv, 1);
        chk("t5_gap_to_idle", c - vpos, 16);
        chk("t5_idle_pins", {busy, cs_n, sck}, 3'b010);
        chk("t5_data", data, 12'h123);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (!cs_n || busy || data_valid) lows++;
        end
        chk("t5_stays_idle", lows, 0);

        // Test 3: reset during the 7th sck pulse
        tx_word = mk(12'h777);
        start_en = 1'b1;
        c = 0;
        while (cs_n && c < 60) begin @(negedge clk); c++; end
        r = 0; ps = sck;
        while (r < 7 && c < 300) begin
            @(negedge clk); c++;
            if (sck && !ps) r++;
            ps = sck;
        end
        chk("t3_in_pulse7", {sck, cs_n}, 2'b10);
        reset = 1'b1;
        @(negedge clk);
        chk("t3_abort_pins", {cs_n, sck, mosi, data_valid, busy, above_hi, below_lo}, 7'b1000000);
        chk("t3_abort_data", data, 12'h000);
        lows = 0;
        repeat (3) begin
            @(negedge clk);
            if (data_valid || !cs_n) lows++;
        end
        chk("t3_quiet_in_reset", lows, 0);
        tx_word = mk(12'h0FF);
        reset = 1'b0;
        measure_frame();
        chk("t3_restart_lat", f_lat, 1);
        chk("t3_frame_len", f_len, 136);
        chk("t3_no_early_valid", f_dv, 0);
        chk("t3_valid", data_valid, 1'b1);
        chk("t3_data", data, 12'h0FF);
        chk("t3_data_ch", data_ch, 1'b0);
        chk("t3_flags", {above_hi, below_lo}, 2'b01);
        start_en = 1'b0;
        c = 0;
        while (busy && c < 100) begin @(negedge clk); c++; end
        chk("t3_idle", busy, 1'b0);

        // Test 2: four-channel scan with start_en held
        start_en4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            kk = 2'(k % 4);
            c = 0;
            while (cs_n4 && c < 60) begin @(negedge clk); c++; end
            chk("t2_cs_fall", cs_n4, 1'b0);
            r = 0; ps = sck4; mword = 16'h0;
            while (r < 16 && c < 400) begin
                @(negedge clk); c++;
                if (sck4 && !ps) begin mword = {mword[14:0], mosi4}; r++; end
                ps = sck4;
            end
            chk("t2_mosi_word", mword, {kk, 14'b0});
            while (!dv4 && c < 500) begin @(negedge clk); c++; end
            chk("t2_valid", {dv4, cs_n4}, 2'b11);
            chk("t2_data_ch", data_ch4, kk);
            chk("t2_data", data4, 12'hFFF);
            if (k == 4) start_en4 = 1'b0;
            g = 0;
            while (cs_n4 && busy4 && g < 100) begin g++; @(negedge clk); end
            if (k < 4) chk("t2_gap_len", g, 16);
        end
        c = 0;
        while (busy4 && c < 100) begin @(negedge clk); c++; end
        chk("t2_idle", {busy4, cs_n4}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
